queue_sched: RTL and testbench

- Round-robin scheduler that shares the single serial output path of the chip between NQ input queues.
- Picks a non-empty queue and pops words from it one at a time.
- Hands each word to the parallel-to-serial shifter with a load/ready handshake, sending at most MAX_BURST words per grant before rotating.
- Sits between the queue bank and the output serializer; clocked by the serial clock domain.

---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_sched_rr_pick.sv | 34 +++
 rtl/queue_sched.sv | 135 +++++++++++++
 tb/tb_queue_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared scheduler state encoding and default sizing
package queue_pkg;

  // Scheduler FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // Default sizing shared with the queue bank and the serializer
  localparam int NQ_DEF        = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/queue_sched_rr_pick.sv
// rtl/queue_sched_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int NQ = 4,
  parameter int IW = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic [NQ-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NQ-1:0] win,
  output logic [IW-1:0] win_idx
);

  // Search upward from last+1, wrapping modulo NQ; the first requester wins
  always_comb begin
    int          cand;
    logic        found;
    logic [IW-1:0] ci;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    ci      = '0;
    for (int k = 1; k <= NQ; k++) begin
      cand = int'(last) + k;
      if (cand >= NQ) cand = cand - NQ;
      ci = IW'(cand);
      if (!found && req[ci]) begin
        found       = 1'b1;
        win[ci]     = 1'b1;
        win_idx     = ci;
      end
    end
  end

endmodule

// File: rtl/queue_sched.sv
// rtl/queue_sched.sv - round-robin scheduler from queue bank to serializer
module queue_sched
  import queue_pkg::*;
#(
  parameter int NQ        = NQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             ser_clk,
  input  logic             reset,
  input  logic [NQ-1:0]    q_req,
  input  logic [NQ*DW-1:0] q_data,
  output logic [NQ-1:0]    q_pop,
  input  logic             ser_ready,
  output logic             ser_load,
  output logic [DW-1:0]    ser_data,
  output logic [NQ-1:0]    grant,
  output logic             sched_busy
);

  localparam int IW = (NQ > 1) ? $clog2(NQ) : 1;

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt;
  logic [IW-1:0] g_idx, g_nxt;
  logic [3:0]    burst_cnt, burst_nxt;
  logic [NQ-1:0] q_pop_nxt, grant_nxt;
  logic          ser_load_nxt, busy_nxt;
  logic [DW-1:0] ser_data_nxt;
  logic [NQ-1:0] pick_win;
  logic [IW-1:0] pick_idx;
  logic          burst_done;

  rr_pick #(.NQ(NQ), .IW(IW)) u_pick (
    .req     (q_req),
    .last    (last_grant),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  assign burst_done = (burst_cnt == 4'(MAX_BURST));

  // State register; reset overrides every transition
  always_ff @(posedge ser_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|q_req) state_nxt = S_GRANT;
      S_GRANT: begin
        if (!q_req[g_idx])  state_nxt = S_IDLE;
        else if (ser_ready) state_nxt = S_POP;
      end
      S_POP:   state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (ser_ready) begin
          if (burst_done || !q_req[g_idx]) state_nxt = S_IDLE;
          else                             state_nxt = S_GRANT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and grant bookkeeping
  always_comb begin
    q_pop_nxt    = '0;
    ser_load_nxt = 1'b0;
    ser_data_nxt = ser_data;
    grant_nxt    = grant;
    burst_nxt    = burst_cnt;
    last_nxt     = last_grant;
    g_nxt        = g_idx;
    busy_nxt     = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (|q_req) begin
          grant_nxt = pick_win;
          g_nxt     = pick_idx;
          burst_nxt = 4'd0;
        end
      end
      S_GRANT: begin
        if (!q_req[g_idx]) begin
          grant_nxt = '0;
          last_nxt  = g_idx;
        end else if (ser_ready) begin
          // grant is one-hot on the owner, so it doubles as the pop strobe
          q_pop_nxt = grant;
        end
      end
      S_LOAD: begin
        ser_data_nxt = q_data[g_idx*DW +: DW];
        ser_load_nxt = 1'b1;
        burst_nxt    = burst_cnt + 4'd1;
      end
      S_WAIT: begin
        if (ser_ready && (burst_done || !q_req[g_idx])) begin
          grant_nxt = '0;
          last_nxt  = g_idx;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; last_grant resets to NQ-1 so queue 0 wins first
  always_ff @(posedge ser_clk) begin
    if (reset) begin
      q_pop      <= '0;
      ser_load   <= 1'b0;
      ser_data   <= '0;
      grant      <= '0;
      sched_busy <= 1'b0;
      burst_cnt  <= 4'd0;
      last_grant <= IW'(NQ - 1);
      g_idx      <= '0;
    end else begin
      q_pop      <= q_pop_nxt;
      ser_load   <= ser_load_nxt;
      ser_data   <= ser_data_nxt;
      grant      <= grant_nxt;
      sched_busy <= busy_nxt;
      burst_cnt  <= burst_nxt;
      last_grant <= last_nxt;
      g_idx      <= g_nxt;
    end
  end

endmodule

// File: tb/tb_queue_sched.sv
// tb/tb_queue_sched.sv - randomized self-checking bench for queue_sched
module tb_queue_sched;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             ser_clk = 1'b0;
  logic             reset;
  logic [NQ-1:0]    q_req;
  logic [NQ*DW-1:0] q_data;
  logic [NQ-1:0]    q_pop;
  logic             ser_ready;
  logic             ser_load;
  logic [DW-1:0]    ser_data;
  logic [NQ-1:0]    grant;
  logic             sched_busy;

  queue_sched #(.NQ(NQ), .DW(DW), .MAX_BURST(MB)) dut (
    .ser_clk    (ser_clk),
    .reset      (reset),
    .q_req      (q_req),
    .q_data     (q_data),
    .q_pop      (q_pop),
    .ser_ready  (ser_ready),
    .ser_load   (ser_load),
    .ser_data   (ser_data),
    .grant      (grant),
    .sched_busy (sched_busy)
  );

  always #5 ser_clk = ~ser_clk;

  int checks = 0;
  int errors = 0;

  // queue bank contents and scheduling reference
  logic [DW-1:0] qbuf [NQ][512];
  int            head [NQ];
  int            tail [NQ];
  int            exp_q [$];
  logic [DW-1:0] exp_d [$];
  int            model_last;
  int            pend;
  int            busy;
  int            dmax;
  logic          hold_low;
  int            cyc, first_pop, first_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic update_req();
    for (int i = 0; i < NQ; i++) q_req[i] = (head[i] != tail[i]);
  endtask

  task automatic fill_word(input int q, input logic [DW-1:0] w);
    qbuf[q][tail[q]] = w;
    tail[q]++;
    update_req();
  endtask

  task automatic fill(input int q, input int n);
    for (int k = 0; k < n; k++) fill_word(q, DW'($urandom));
  endtask

  // Reference: rotate from last+1, take up to MB words from each non-empty queue
  task automatic build();
    int c [NQ];
    int hd [NQ];
    int g, n;
    for (int i = 0; i < NQ; i++) begin
      c[i]  = tail[i] - head[i];
      hd[i] = head[i];
    end
    forever begin
      g = -1;
      for (int k = 1; k <= NQ; k++)
        if (g < 0 && c[(model_last + k) % NQ] > 0) g = (model_last + k) % NQ;
      if (g < 0) break;
      n = (c[g] < MB) ? c[g] : MB;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(g);
        exp_d.push_back(qbuf[g][hd[g]]);
        hd[g]++;
      end
      c[g] -= n;
      model_last = g;
    end
  endtask

  // One clock: check outputs, then react as queue bank and serializer
  task automatic step();
    int pi;
    int eq;
    logic [DW-1:0] ed;
    @(posedge ser_clk);
    #1;
    cyc++;
    check("pop_onehot", 32'($countones(q_pop) <= 1), 1);
    check("grant_onehot", 32'($countones(grant) <= 1), 1);
    pi = -1;
    for (int i = 0; i < NQ; i++) if (q_pop[i]) pi = i;
    if (pi >= 0) begin
      check("pop_with_load", 32'(ser_load), 0);
      check("pop_nonempty", 32'((tail[pi] - head[pi]) > 0), 1);
      check("pop_owner", 32'(q_pop), 32'(grant));
      if (first_pop < 0) first_pop = cyc;
    end
    if (ser_load) begin
      if (first_load < 0) first_load = cyc;
      check("load_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        eq = exp_q.pop_front();
        ed = exp_d.pop_front();
        check("load_owner", 32'(grant), 32'(1 << eq));
        check("load_data", 32'(ser_data), 32'(ed));
      end
    end
    if (pend >= 0) begin
      q_data[pend*DW +: DW] = qbuf[pend][head[pend]];
      head[pend]++;
      pend = -1;
      update_req();
    end
    if (pi >= 0) pend = pi;
    if (ser_load) begin
      ser_ready = 1'b0;
      busy = $urandom_range(dmax, 1);
    end else if (!ser_ready && !hold_low) begin
      busy--;
      if (busy <= 0) ser_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sched_busy || !ser_ready) && n < 3000) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 0);
    check("drain_timeout", 32'(n < 3000), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_q_pop"}, 32'(q_pop), 0);
    check({pfx, "_ser_load"}, 32'(ser_load), 0);
    check({pfx, "_ser_data"}, 32'(ser_data), 0);
    check({pfx, "_grant"}, 32'(grant), 0);
    check({pfx, "_busy"}, 32'(sched_busy), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    q_req = '0;
    q_data = '0;
    ser_ready = 1'b1;
    hold_low = 1'b0;
    dmax = 1;
    pend = -1;
    busy = 0;
    model_last = NQ - 1;
    cyc = 0;
    first_pop = -1;
    first_load = -1;
    for (int i = 0; i < NQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;

    // first-word latency from a lone request on queue 0
    cyc = 0;
    first_pop = -1;
    first_load = -1;
    fill_word(0, 8'hA5);
    build();
    drain();
    check("lat_pop", 32'(first_pop), 2);
    check("lat_load", 32'(first_load), 4);

    // two deep queues sharing the output with bursts of MB
    fill(0, 6);
    fill(2, 6);
    build();
    drain();

    // one word on every queue, then a late request on queue 0
    for (int i = 0; i < NQ; i++) fill(i, 1);
    build();
    drain();
    fill(0, 1);
    build();
    drain();

    // serializer busy for 20 cycles while a grant is held
    hold_low = 1'b1;
    ser_ready = 1'b0;
    fill(0, 1);
    build();
    repeat (20) begin
      step();
      check("hold_pop", 32'(q_pop), 0);
      check("hold_load", 32'(ser_load), 0);
    end
    check("hold_grant", 32'(grant), 32'b0001);
    ser_ready = 1'b1;
    hold_low = 1'b0;
    step();
    check("rise_pop", 32'(q_pop), 32'b0001);
    drain();

    // queue 1 runs dry after two words of a four-word burst
    fill(1, 2);
    build();
    drain();
    check("early_grant", 32'(grant), 0);
    check("early_busy", 32'(sched_busy), 0);

    // reset while the popped word is still in flight
    fill(2, 1);
    n = 0;
    while (q_pop == '0 && n < 20) begin
      step();
      n++;
    end
    check("rst_pop_seen", 32'(q_pop), 32'b0100);
    reset = 1'b1;
    step();
    check_reset_outputs("rst_pop");
    reset = 1'b0;
    model_last = NQ - 1;
    repeat (4) step();
    fill(3, 2);
    fill(0, 2);
    build();
    drain();

    // randomized occupancy and serializer back-pressure
    for (int p = 0; p < 8; p++) begin
      dmax = $urandom_range(4, 1);
      for (int i = 0; i < NQ; i++) fill(i, $urandom_range(7, 0));
      build();
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
